// File: rtl/button_led_controller.sv
// Debounced push-button front end driving a mode FSM and PWM brightness onto
// an active-low RGB LED. Buttons [1:0] control mode/brightness; the rest are only exported.
module button_led_controller #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PWM_WIDTH       = 8,
    parameter int BRIGHT_STEP     = 32,
    parameter int CYCLE_TICKS     = 12000000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] push_button_n,
    output logic [NUM_BUTTONS-1:0] button_level,
    output logic [NUM_BUTTONS-1:0] button_press,
    output logic [2:0]             mode,
    output logic [PWM_WIDTH-1:0]   brightness,
    output logic                   led_red_n,
    output logic                   led_green_n,
    output logic                   led_blue_n
);
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CTW = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
    localparam logic [DBW-1:0]       DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CTW-1:0]       CT_LAST    = CTW'(CYCLE_TICKS - 1);
    localparam logic [PWM_WIDTH-1:0] BRIGHT_MAX = '1;
    localparam logic [PWM_WIDTH:0]   STEP_EXT   = (PWM_WIDTH+1)'(BRIGHT_STEP);

    typedef enum logic [2:0] {M_OFF = 3'd0, M_RED = 3'd1, M_GREEN = 3'd2,
                              M_BLUE = 3'd3, M_CYCLE = 3'd4} mode_e;
    typedef enum logic [1:0] {C_RED = 2'd0, C_GREEN = 2'd1, C_BLUE = 2'd2} colour_e;

    logic [NUM_BUTTONS-1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_BUTTONS-1:0][DBW-1:0] db_cnt_q, db_cnt_d;
    logic [NUM_BUTTONS-1:0]          level_q, level_d, press_q, press_d;
    mode_e                           mode_q, mode_d;
    colour_e                         colour_q, colour_d;
    logic [CTW-1:0]                  cyc_cnt_q, cyc_cnt_d;
    logic [PWM_WIDTH-1:0]            bright_q, bright_d, pwm_cnt_q, pwm_cnt_d;
    logic                            led_r_q, led_r_d, led_g_q, led_g_d, led_b_q, led_b_d;
    logic [PWM_WIDTH:0]              bright_sum;
    logic                            pwm_on, sel_r, sel_g, sel_b;

    always_comb begin
        sync1_d  = push_button_n;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        // sync2_q is still active low; a mismatch must persist DEBOUNCE_CYCLES cycles
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (~sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i]  = ~sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
        press_d = level_d & ~level_q;

        mode_d    = mode_q;
        colour_d  = colour_q;
        cyc_cnt_d = cyc_cnt_q;
        if (mode_q == M_CYCLE) begin
            if (cyc_cnt_q == CT_LAST) begin
                cyc_cnt_d = '0;
                case (colour_q)
                    C_RED:   colour_d = C_GREEN;
                    C_GREEN: colour_d = C_BLUE;
                    default: colour_d = C_RED;
                endcase
            end else begin
                cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
        end
        if (press_q[0]) begin
            case (mode_q)
                M_OFF:   mode_d = M_RED;
                M_RED:   mode_d = M_GREEN;
                M_GREEN: mode_d = M_BLUE;
                M_BLUE: begin
                    mode_d    = M_CYCLE;
                    cyc_cnt_d = '0;
                    colour_d  = C_RED;
                end
                default: mode_d = M_OFF;
            endcase
        end

        bright_sum = {1'b0, bright_q} + STEP_EXT;
        bright_d   = bright_q;
        if (press_q[1]) begin
            if (bright_q == BRIGHT_MAX)
                bright_d = '0;
            else if (bright_sum > {1'b0, BRIGHT_MAX})
                bright_d = BRIGHT_MAX;
            else
                bright_d = bright_sum[PWM_WIDTH-1:0];
        end

        pwm_cnt_d = pwm_cnt_q + 1'b1;
        // max brightness is forced fully on, since pwm_cnt never exceeds max
        pwm_on  = (pwm_cnt_q < bright_q) | (bright_q == BRIGHT_MAX);
        sel_r   = (mode_q == M_RED)   | ((mode_q == M_CYCLE) & (colour_q == C_RED));
        sel_g   = (mode_q == M_GREEN) | ((mode_q == M_CYCLE) & (colour_q == C_GREEN));
        sel_b   = (mode_q == M_BLUE)  | ((mode_q == M_CYCLE) & (colour_q == C_BLUE));
        led_r_d = ~(sel_r & pwm_on);
        led_g_d = ~(sel_g & pwm_on);
        led_b_d = ~(sel_b & pwm_on);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            db_cnt_q  <= '0;
            level_q   <= '0;
            press_q   <= '0;
            mode_q    <= M_OFF;
            colour_q  <= C_RED;
            cyc_cnt_q <= '0;
            bright_q  <= BRIGHT_MAX;
            pwm_cnt_q <= '0;
            led_r_q   <= 1'b1;
            led_g_q   <= 1'b1;
            led_b_q   <= 1'b1;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            mode_q    <= mode_d;
            colour_q  <= colour_d;
            cyc_cnt_q <= cyc_cnt_d;
            bright_q  <= bright_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_r_q   <= led_r_d;
            led_g_q   <= led_g_d;
            led_b_q   <= led_b_d;
        end
    end

    assign button_level = level_q;
    assign button_press = press_q;
    assign mode         = mode_q;
    assign brightness   = bright_q;
    assign led_red_n    = led_r_q;
    assign led_green_n  = led_g_q;
    assign led_blue_n   = led_b_q;
endmodule
